// File: rtl/lenet5_frame_sequencer.sv
// LeNet-5 frame sequencer: clears the network, streams one frame of pixels, drains, latches the class.
// Optional abort path is compiled in when LENET_SEQ_ABORT_EN is defined.
module lenet5_frame_sequencer #(
    parameter int NUMPIXELS    = 1024,
    parameter int PIXELWIDTH   = 8,
    parameter int ADDRW        = 10,
    parameter int DRAIN_CYCLES = 64,
    parameter int CLASSW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef LENET_SEQ_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    input  logic                  start,
    output logic [ADDRW-1:0]      pix_addr,
    input  logic [PIXELWIDTH-1:0] pix_data_in,
    output logic [PIXELWIDTH-1:0] pix_out,
    output logic                  pix_valid,
    output logic                  net_clear,
    input  logic [CLASSW-1:0]     net_class_in,
    output logic [CLASSW-1:0]     result,
    output logic                  done,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [ADDRW-1:0] LAST_ADDR  = ADDRW'(NUMPIXELS - 1);
    localparam logic [15:0]      DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDRW-1:0]        r_addr;
    logic [15:0]             r_drain;
    logic [CLASSW-1:0]       r_result;
    logic [15:0]             r_frame_count;
    logic                    r_vld_p1;
    logic                    r_vld_p2;
    logic [PIXELWIDTH-1:0]   r_pix_p2;
    logic                    w_abort_hit;
    logic                    w_stream_hold;
    logic                    w_drain_hold;
    logic                    w_drain_exit;

`ifdef LENET_SEQ_ABORT_EN
    logic r_aborted;

    // Abort only matters while a frame is actually in flight
    assign w_abort_hit = abort &&
                         ((r_state == S_CLEAR) || (r_state == S_STREAM) || (r_state == S_DRAIN));
    assign aborted     = r_aborted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort_hit;
        end
    end
`else
    assign w_abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_STREAM;
            S_STREAM: if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN:  if (r_drain == DRAIN_LAST) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort_hit) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        net_clear = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        pix_addr  = '0;
        case (r_state)
            S_IDLE:   busy      = 1'b0;
            S_CLEAR:  net_clear = 1'b1;
            S_STREAM: pix_addr  = r_addr;
            S_DONE:   done      = 1'b1;
            default:  ;
        endcase
    end

    assign w_stream_hold = (r_state == S_STREAM) && (w_next == S_STREAM);
    assign w_drain_hold  = (r_state == S_DRAIN)  && (w_next == S_DRAIN);
    assign w_drain_exit  = (r_state == S_DRAIN)  && (w_next == S_DONE);

    // Counters run only while their state persists, so they are back at 0 for the next frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr        <= '0;
            r_drain       <= '0;
            r_result      <= '0;
            r_frame_count <= '0;
        end else begin
            r_addr  <= w_stream_hold ? r_addr + 1'b1 : '0;
            r_drain <= w_drain_hold ? r_drain + 16'd1 : '0;
            if (w_drain_exit) begin
                r_result      <= net_class_in;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // p1: address issued last cycle, memory data arrives now; p2: pixel registered to the network
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_pix_p2 <= '0;
        end else begin
            r_vld_p1 <= (r_state == S_STREAM) && !w_abort_hit;
            r_vld_p2 <= r_vld_p1 && !w_abort_hit;
            if (r_vld_p1) begin
                r_pix_p2 <= pix_data_in;
            end
        end
    end

    assign pix_out     = r_pix_p2;
    assign pix_valid   = r_vld_p2;
    assign result      = r_result;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_lenet5_frame_sequencer.sv
// Self-checking bench for lenet5_frame_sequencer with a cycle-indexed frame timeline model.
module tb_lenet5_frame_sequencer;

    localparam int N  = 16;
    localparam int D  = 4;
    localparam int AW = 4;
    localparam int PW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pix_addr;
    logic [PW-1:0] pix_data_in;
    logic [PW-1:0] pix_out;
    logic          pix_valid;
    logic          net_clear;
    logic [CW-1:0] net_class_in;
    logic [CW-1:0] result;
    logic          done;
    logic          busy;
    logic [15:0]   frame_count;
`ifdef LENET_SEQ_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    logic [PW-1:0] mem [N];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [15:0]   exp_fc;
    logic [CW-1:0] exp_result;

    always #5 clk = ~clk;

    always @(posedge clk) pix_data_in <= mem[pix_addr];

    lenet5_frame_sequencer #(
        .NUMPIXELS(N), .PIXELWIDTH(PW), .ADDRW(AW), .DRAIN_CYCLES(D), .CLASSW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef LENET_SEQ_ABORT_EN
        .abort(abort),
        .aborted(aborted),
`endif
        .start(start),
        .pix_addr(pix_addr),
        .pix_data_in(pix_data_in),
        .pix_out(pix_out),
        .pix_valid(pix_valid),
        .net_clear(net_clear),
        .net_class_in(net_class_in),
        .result(result),
        .done(done),
        .busy(busy),
        .frame_count(frame_count)
    );

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < N; i++) begin
            mem[i] = ramp ? PW'(i + 16) : PW'($urandom);
        end
    endtask

    // One frame from an IDLE negedge: t counts posedges since the start edge.
    // CLEAR at t=1, address k at t=2+k, valid pixel k at t=4+k, DONE at t=N+D+2, IDLE again at t=N+D+3.
    task automatic run_frame(input string tag, input bit hold_start, input bit abort_poke, input int fixed_cls);
        logic [CW-1:0] cls_at_exit;
        cls_at_exit = exp_result;
        start = 1'b1;
`ifdef LENET_SEQ_ABORT_EN
        abort = abort_poke;
`endif
        for (int t = 1; t <= N + D + 3; t++) begin
            logic          e_clr, e_busy, e_done, e_vld;
            logic [AW-1:0] e_addr;
            logic [27:0]   got, want;
            @(negedge clk);
            if (t == N + D + 2) begin
                exp_fc     = exp_fc + 16'd1;
                exp_result = cls_at_exit;
            end
            e_clr  = (t == 1);
            e_busy = (t <= N + D + 2);
            e_done = (t == N + D + 2);
            e_vld  = (t >= 4) && (t <= N + 3);
            e_addr = ((t >= 2) && (t <= N + 1)) ? AW'(t - 2) : '0;
            got  = {net_clear, busy, done, pix_valid, pix_addr, frame_count, result};
            want = {e_clr, e_busy, e_done, e_vld, e_addr, exp_fc, exp_result};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s t=%0d {clr,busy,done,vld,addr,fc,res} got %h want %h", tag, t, got, want);
            end
            if (e_vld) begin
                n_cmp++;
                if (pix_out !== mem[t - 4]) begin
                    n_fail++;
                    $display("FAIL %s pix_out t=%0d got %h want %h", tag, t, pix_out, mem[t - 4]);
                end
            end
`ifdef LENET_SEQ_ABORT_EN
            n_cmp++;
            if (aborted !== 1'b0) begin
                n_fail++;
                $display("FAIL %s aborted t=%0d got %b want 0", tag, t, aborted);
            end
            abort = abort_poke && (t == N + D + 2);
`endif
            start = hold_start;
            net_class_in = CW'($urandom_range(0, 15));
            if (t == N + D + 1) begin
                if (fixed_cls >= 0) net_class_in = CW'(fixed_cls);
                cls_at_exit = net_class_in;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        net_class_in = '0;
`ifdef LENET_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        fill_mem(1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({net_clear, busy, done, pix_valid, pix_addr, frame_count, result, pix_out} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got %h want 0",
                     {net_clear, busy, done, pix_valid, pix_addr, frame_count, result, pix_out});
        end
        exp_fc = 16'd0;
        exp_result = '0;
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        fill_mem(1'b1);
        run_frame("nominal", 1'b0, 1'b0, -1);
    endtask

    task automatic test_result_latch();
        fill_mem(1'b0);
        run_frame("latch", 1'b0, 1'b0, 7);
        net_class_in = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (result !== 4'd7 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL latch_hold cycle=%0d result=%0d busy=%b want result=7 busy=0", i, result, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            fill_mem(1'b0);
            run_frame("b2b", 1'b1, 1'b0, -1);
        end
        fill_mem(1'b0);
        run_frame("b2b_last", 1'b0, 1'b0, -1);
    endtask

    task automatic test_midstream_reset();
        bit seen;
        bit saw_done;
        seen = 1'b0;
        saw_done = 1'b0;
        fill_mem(1'b0);
        start = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && pix_addr == AW'(9)) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrst_reach_addr9 got addr=%0d want 9 within 40 cycles", pix_addr);
        end
        #2 rst = 1'b0;
        #1;
        exp_fc = 16'd0;
        exp_result = '0;
        n_cmp++;
        if ({net_clear, busy, done, pix_valid, pix_addr, frame_count, result, pix_out} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got %h want 0",
                     {net_clear, busy, done, pix_valid, pix_addr, frame_count, result, pix_out});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_no_done saw_done=%b fc=%0d want 0/0", saw_done, frame_count);
        end
        rst = 1'b1;
        fill_mem(1'b0);
        run_frame("after_midrst", 1'b0, 1'b0, -1);
    endtask

    task automatic test_wrap();
        force dut.r_frame_count = 16'hFFFF;
        #1 release dut.r_frame_count;
        exp_fc = 16'hFFFF;
        fill_mem(1'b0);
        run_frame("wrap", 1'b0, 1'b0, -1);
    endtask

`ifdef LENET_SEQ_ABORT_EN
    task automatic test_abort();
        bit seen;
        seen = 1'b0;
        fill_mem(1'b0);
        start = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && pix_addr == AW'(5)) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL abort_reach_addr5 got addr=%0d want 5 within 40 cycles", pix_addr);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({aborted, pix_valid, busy, done, net_clear, result, frame_count} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_result, exp_fc}) begin
            n_fail++;
            $display("FAIL abort_cycle {ab,vld,busy,done,clr,res,fc} got %h want %h",
                     {aborted, pix_valid, busy, done, net_clear, result, frame_count},
                     {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_result, exp_fc});
        end
        @(negedge clk);
        n_cmp++;
        if ({aborted, pix_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_after {ab,vld,busy} got %b want 000", {aborted, pix_valid, busy});
        end
        fill_mem(1'b1);
        run_frame("abort_then_frame", 1'b0, 1'b1, -1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_result_latch();
        test_back_to_back();
        test_midstream_reset();
        test_wrap();
`ifdef LENET_SEQ_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lenet5_frame_sequencer.md
LENET5_FRAME_SEQUENCER -- requirements
Module: lenet5_frame_sequencer

Interface
REQ-001 Parameter NUMPIXELS, default 1024: pixels per frame; allowed range 2..65536.
REQ-002 Parameter PIXELWIDTH, default 8: pixel bit width.
REQ-003 Parameter ADDRW, default 10: pixel address width; must satisfy 2^ADDRW >= NUMPIXELS.
REQ-004 Parameter DRAIN_CYCLES, default 64: network flush cycles after the last address; allowed range 2..65535.
REQ-005 Parameter CLASSW, default 4: classification result width.
REQ-006 Port clk, input, 1: single clock; all state updates on posedge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Port start, input, 1: frame request; sampled only in IDLE.
REQ-009 Port pix_addr, output, ADDRW: image memory read address.
REQ-010 Port pix_data_in, input, PIXELWIDTH: memory read data; valid 1 cycle after its address.
REQ-011 Port pix_out, output, PIXELWIDTH: registered pixel to the network.
REQ-012 Port pix_valid, output, 1: pix_out is valid this cycle.
REQ-013 Port net_clear, output, 1: one-cycle network flush pulse.
REQ-014 Port net_class_in, input, CLASSW: network classification output.
REQ-015 Port result, output, CLASSW: latched classification result.
REQ-016 Port done, output, 1: one-cycle frame-complete pulse.
REQ-017 Port busy, output, 1: high in every state except IDLE.
REQ-018 Port frame_count, output, 16: number of completed frames; wraps from 65535 to 0.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-020 IDLE SHALL go to CLEAR on the edge where start=1; start in any other state SHALL be ignored.
REQ-021 CLEAR SHALL last exactly 1 cycle with net_clear=1, then go to STREAM; net_clear SHALL be 0 in all other states.
REQ-022 STREAM SHALL issue one address per cycle: 0, 1, ... NUMPIXELS-1, no gaps, NUMPIXELS cycles total; it SHALL go to DRAIN after address NUMPIXELS-1.
REQ-023 Outside STREAM, pix_addr SHALL hold 0.
REQ-024 pix_out SHALL be pix_data_in registered; pix_valid SHALL be asserted exactly 2 cycles after each address issue.
REQ-025 Each frame SHALL produce exactly NUMPIXELS contiguous pix_valid cycles.
REQ-026 DRAIN SHALL last exactly DRAIN_CYCLES cycles (counter counts 0..DRAIN_CYCLES-1), then go to DONE.
REQ-027 The final pix_valid SHALL fall inside DRAIN, which is guaranteed by DRAIN_CYCLES >= 2.
REQ-028 On DRAIN exit, result SHALL load net_class_in; result SHALL hold that value until the next DRAIN exit.
REQ-029 DONE SHALL last 1 cycle with done=1 and frame_count incremented by 1, then go to IDLE.
REQ-030 start=1 during DONE SHALL be ignored; a new frame needs start high while in IDLE.
REQ-031 Latency from the start edge to the done pulse SHALL be 1 + NUMPIXELS + DRAIN_CYCLES + 1 cycles.
REQ-032 Address and drain counters SHALL NOT wrap inside a frame; the address counter SHALL be ADDRW bits and SHALL stop at NUMPIXELS-1.

Reset
REQ-033 When rst=0, the block SHALL asynchronously enter IDLE.
REQ-034 Reset values SHALL be: pix_addr=0, pix_out=0, pix_valid=0, net_clear=0, result=0, done=0, busy=0, frame_count=0, all counters 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame: no done pulse and no frame_count change.
REQ-036 After rst releases, start SHALL be honoured from the first posedge.

Configuration
REQ-037 Macro LENET_SEQ_ABORT_EN, when defined, SHALL add input abort (1 bit) and output aborted (1 bit).
REQ-038 With LENET_SEQ_ABORT_EN, abort=1 in CLEAR, STREAM or DRAIN SHALL return the FSM to IDLE on the next edge, with aborted=1 for that 1 cycle.
REQ-039 On abort, pix_valid SHALL be forced to 0 from the next cycle, even if reads are in flight; result and frame_count SHALL be unchanged.
REQ-040 On abort, done SHALL NOT pulse.
REQ-041 With LENET_SEQ_ABORT_EN, abort in IDLE or DONE SHALL be ignored; if abort and start are both high in IDLE, start SHALL win.
REQ-042 Without LENET_SEQ_ABORT_EN, ports abort and aborted SHALL NOT exist and the FSM SHALL have no abort path.

Verification
REQ-043 Scenario, nominal frame: NUMPIXELS=16, DRAIN_CYCLES=4, memory data = address+8'h10, start pulse -> pix_out 8'h10..8'h1F on 16 consecutive pix_valid cycles; done 22 cycles after start edge; frame_count=1.
REQ-044 Scenario, result latch: net_class_in=4'd7 at DRAIN exit, then changed to 4'd2 -> result=7 and held through IDLE.
REQ-045 Scenario, ignored start: start held high for the entire frame -> exactly one CLEAR pulse per IDLE entry; frames run back-to-back; frame_count increments by 1 per done.
REQ-046 Scenario, mid-stream reset: rst=0 at address 9 -> all outputs 0 immediately; no done; frame_count=0.
REQ-047 Scenario, frame_count wrap: frame_count preloaded to 65535 via 65535 short frames (or forced), one more frame -> frame_count=0 on done.
REQ-048 Scenario, abort (LENET_SEQ_ABORT_EN defined): abort at address 5 -> aborted pulses 1 cycle; pix_valid low from next cycle; busy=0; result unchanged; next start runs a full 16-pixel frame.
